alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between NREQ requesters, e.g. the core datapath port and a multi-cycle helper such as an address generator or an iterative mul/div sequencer.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Requests are granted round-robin. Operands are registered into the ALU, and the result and flags are registered back to the winning requester.
- Illegal opcodes are answered with an error response without using the ALU.

Parameters:
WIDTH, 32, operand/result width
NREQ, 2, number of requesters (2..8)
IDW, 3, width of owner index (>= clog2(NREQ))

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
req_valid  input  NREQ  request valid, one bit per requester
req_ready  output  NREQ  request accepted (one-hot or zero)
req_a  input  NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  operand b, same packing
req_ctrl  input  NREQ*4  ALU opcode, requester i at [i*4 +: 4]
resp_valid  output  NREQ  response valid, one-hot or zero
resp_ready  input  NREQ  response consumed
resp_out  output  WIDTH  registered ALU result (shared by all requesters)
resp_flags  output  4  registered {overflow, carry, negative, zero}
resp_err  output  1  opcode was illegal (> 4'b1100)
busy  output  1  state != IDLE
owner  output  IDW  index of current or last granted requester
alu_a  output  WIDTH  to ALU operand a (registered)
alu_b  output  WIDTH  to ALU operand b (registered)
alu_ctrl  output  4  to ALU opcode (registered)
alu_out  input  WIDTH  from ALU result
alu_zero, alu_negative, alu_carry, alu_overflow  input  1 each  from ALU flags

Behaviour:
- Reset values:
  - state=IDLE, ptr=0, owner=0.
  - alu_a=0, alu_b=0, alu_ctrl=4'b0000.
  - resp_out=0, resp_flags=0, resp_err=0.
  - req_ready=0, resp_valid=0, busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Combinationally select the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping mod NREQ.
  - req_ready[i]=1 for that i only. req_ready is 0 in all other states.
  - On the handshake, register owner=i and alu_a/alu_b/alu_ctrl from requester i's fields.
  - Next state is EXEC if opcode <= 4'b1100.
  - If the opcode is illegal, go directly to RESP with resp_out=0, resp_flags=0, resp_err=1; alu_ctrl is left unchanged.
  - With no req_valid bits set: stay in IDLE, all outputs hold.
- EXEC (exactly one cycle):
  - Capture resp_out=alu_out and resp_flags={alu_overflow, alu_carry, alu_negative, alu_zero}, resp_err=0.
  - Go to RESP.
- RESP:
  - resp_valid[owner]=1.
  - Stay in RESP while resp_ready[owner]=0; resp_out, resp_flags and resp_err hold stable.
  - resp_ready bits of non-owners are ignored.
  - On resp_ready[owner]=1: go to IDLE and set ptr=(owner+1) mod NREQ.
  - RESP does not accept a new request in the same cycle.
- Latency and throughput:
  - Handshake at cycle T gives resp_valid at T+2 (legal op) or T+1 (illegal op).
  - Maximum throughput is one op per 3 cycles with resp_ready tied high.
- Fairness: a requester holding req_valid continuously is granted within NREQ grants.
- ALU drive: alu_a, alu_b and alu_ctrl change only on an IDLE handshake with a legal opcode. Between ops they hold their last values; they are not cleared.
- Requester-side rules:
  - Request fields must be stable while req_valid=1 and req_ready=0.
  - A requester may drop req_valid before being granted; no grant occurs and there is no side effect.
- Reset mid-operation: a reset asserted in EXEC or RESP drops the in-flight operation silently, returns to the reset values next cycle, and produces no response.
- ptr is not advanced on an illegal-op response any differently than on a legal one; the same rule applies to both.
- Width rules: operands pass through unmodified; no sign extension or truncation is done in this block.

Test Plan:
- Single requester: req0 with a=5, b=3, ctrl=0001.
  - Expected: req_ready[0] at T; alu_a=5, alu_b=3, alu_ctrl=1 at T+1.
  - Expected: resp_valid[0] at T+2 with resp_out=2, zero=0, carry=1.
- Simultaneous requests: req0 (ADD 1+1) and req1 (XOR F0^0F) both held valid from reset, resp_ready=1.
  - Expected: grant order 0,1,0,1.
  - Expected: resp_out=2 to req0 and 0xFF to req1, each with the matching one-hot resp_valid.
- Response backpressure: hold resp_ready[0]=0 for 5 cycles after an SLT (-1 < 1) op.
  - Expected: resp_valid[0] and resp_out=1 held stable; req_ready=0 throughout; req1's pending request waits.
  - Expected: after resp_ready[0]=1, req1 is granted on the next cycle.
- Illegal opcode: req1 with ctrl=4'b1111.
  - Expected: resp_valid[1] at T+1, resp_err=1, resp_out=0, resp_flags=0.
  - Expected: alu_ctrl unchanged.
- Reset in RESP: assert reset while resp_valid[0]=1.
  - Expected: next cycle resp_valid=0, busy=0, ptr=0, all outputs at reset values.
  - Expected: a subsequent req1-only request is granted normally.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: per-requester request and response
// handshakes plus the shared registered result.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*4-1:0]     req_ctrl;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [WIDTH-1:0]      resp_out;
    logic [3:0]            resp_flags;
    logic                  resp_err;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, resp_ready,
        input  req_ready, resp_valid, resp_out, resp_flags, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, resp_ready,
        output req_ready, resp_valid, resp_out, resp_flags, resp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters;
// operands are registered into the ALU and results registered back to the winner.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    alu_arbiter_if.slave     bus,
    output logic             busy,
    output logic [IDW-1:0]   owner,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_carry,
    input  logic             alu_overflow
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [3:0] LAST_LEGAL_OP = 4'b1100;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic             found;
    logic [IDW-1:0]   sel;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_ctrl;
    logic             owner_ready;
    logic [IDW-1:0]   next_ptr;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && bus.req_valid[i] &&
                    ((int'(ptr) + k == i) || (int'(ptr) + k == i + NREQ))) begin
                    found = 1'b1;
                    sel   = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        sel_a          = '0;
        sel_b          = '0;
        sel_ctrl       = '0;
        owner_ready    = 1'b0;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(sel) == i) begin
                sel_a    = bus.req_a[i*WIDTH +: WIDTH];
                sel_b    = bus.req_b[i*WIDTH +: WIDTH];
                sel_ctrl = bus.req_ctrl[i*4 +: 4];
            end
            if (int'(owner) == i) begin
                owner_ready = bus.resp_ready[i];
            end
            bus.req_ready[i]  = (state == IDLE) && found && !reset && (int'(sel) == i);
            bus.resp_valid[i] = (state == RESP) && (int'(owner) == i);
        end
    end

    assign next_ptr = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
    assign busy     = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= '0;
            owner          <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_ctrl       <= 4'b0000;
            bus.resp_out   <= '0;
            bus.resp_flags <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= sel;
                        if (sel_ctrl <= LAST_LEGAL_OP) begin
                            alu_a    <= sel_a;
                            alu_b    <= sel_b;
                            alu_ctrl <= sel_ctrl;
                            state    <= EXEC;
                        end else begin
                            // Illegal op bypasses the ALU and leaves its inputs untouched.
                            bus.resp_out   <= '0;
                            bus.resp_flags <= '0;
                            bus.resp_err   <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end
                EXEC: begin
                    bus.resp_out   <= alu_out;
                    bus.resp_flags <= {alu_overflow, alu_carry, alu_negative, alu_zero};
                    bus.resp_err   <= 1'b0;
                    state          <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios, then randomized
// traffic against a transaction-level reference model.
module tb_alu_arbiter;
    localparam int WIDTH = 32;
    localparam int NREQ  = 3;
    localparam int IDW   = 3;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flags;
    } alu_res_t;

    logic             clk;
    logic             reset;
    logic             busy;
    logic [IDW-1:0]   owner;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [3:0]       alu_ctrl;
    logic             alu_zero, alu_negative, alu_carry, alu_overflow;
    alu_res_t         alu_r;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .owner        (owner),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU; flags packed {overflow, carry, negative, zero}.
    function automatic alu_res_t alu_fn(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        w = '0;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                        v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; c = w[32];
                        v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  r = (a < b) ? 32'd1 : 32'd0;
            4'd7:  r = a << b[4:0];
            4'd8:  r = a >> b[4:0];
            4'd9:  r = $signed(a) >>> b[4:0];
            4'd10: r = ~(a | b);
            4'd11: r = a;
            4'd12: r = b;
            default: r = '0;
        endcase
        return {r, {v, c, r[31], (r == 32'd0)}};
    endfunction

    always_comb alu_r = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_out      = alu_r.res;
    assign alu_overflow = alu_r.flags[3];
    assign alu_carry    = alu_r.flags[2];
    assign alu_negative = alu_r.flags[1];
    assign alu_zero     = alu_r.flags[0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
        bus.req_valid[i]            = v;
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
        bus.req_ctrl[i*4 +: 4]      = op;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_ctrl   = '0;
        bus.resp_ready = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_ctrl"}, alu_ctrl, 0);
        check({tag, "_resp_out"}, bus.resp_out, 0);
        check({tag, "_resp_flags"}, bus.resp_flags, 0);
        check({tag, "_resp_err"}, bus.resp_err, 0);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_resp_valid"}, bus.resp_valid, 0);
    endtask

    // Returns at the negedge where the awaited event is visible.
    task automatic wait_for(input bit want_grant, input string tag);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (want_grant ? (bus.req_ready != 0) : (bus.resp_valid != 0)) return;
            @(posedge clk);
            #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: got no event expected event within 20 cycles", tag);
    endtask

    // Transaction-level reference model state.
    bit          m_busy;
    int          m_owner, m_countdown, m_rr;
    logic [31:0] m_out, m_alu_a, m_alu_b;
    logic [3:0]  m_flags, m_alu_ctrl;
    bit          m_err;
    bit          granted [NREQ];

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 3));
            1:       return ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (granted[i]) begin
                granted[i]       = 1'b0;
                bus.req_valid[i] = 1'b0;
            end
            if (!bus.req_valid[i]) begin
                if ($urandom_range(0, 99) < 40)
                    set_req(i, 1'b1, rand_operand(), rand_operand(), 4'($urandom_range(0, 15)));
            end else if ($urandom_range(0, 99) < 5) begin
                bus.req_valid[i] = 1'b0;
            end
            bus.resp_ready[i] = ($urandom_range(0, 99) < 60);
        end
    endtask

    task automatic model_step();
        int               win;
        logic [NREQ-1:0]  exp_mask;
        logic [31:0]      fa, fb;
        logic [3:0]       fop;
        alu_res_t         r;
        check("rnd_busy", busy, m_busy);
        check("rnd_owner", owner, m_owner);
        check("rnd_alu_a", alu_a, m_alu_a);
        check("rnd_alu_b", alu_b, m_alu_b);
        check("rnd_alu_ctrl", alu_ctrl, m_alu_ctrl);
        if (m_busy) begin
            check("rnd_ready_busy", bus.req_ready, 0);
            if (m_countdown > 0) m_countdown--;
            if (m_countdown == 0) begin
                exp_mask = '0;
                exp_mask[m_owner] = 1'b1;
                check("rnd_resp_valid", bus.resp_valid, exp_mask);
                check("rnd_resp_out", bus.resp_out, m_out);
                check("rnd_resp_flags", bus.resp_flags, m_flags);
                check("rnd_resp_err", bus.resp_err, m_err);
                if (bus.resp_ready[m_owner]) begin
                    m_busy = 1'b0;
                    m_rr   = (m_owner + 1) % NREQ;
                end
            end else begin
                check("rnd_resp_early", bus.resp_valid, 0);
            end
        end else begin
            check("rnd_resp_idle", bus.resp_valid, 0);
            win = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (win < 0 && bus.req_valid[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
            end
            exp_mask = '0;
            if (win >= 0) exp_mask[win] = 1'b1;
            check("rnd_grant", bus.req_ready, exp_mask);
            if (win >= 0) begin
                granted[win] = 1'b1;
                fa  = bus.req_a[win*WIDTH +: WIDTH];
                fb  = bus.req_b[win*WIDTH +: WIDTH];
                fop = bus.req_ctrl[win*4 +: 4];
                m_busy  = 1'b1;
                m_owner = win;
                if (fop <= 4'd12) begin
                    r = alu_fn(fa, fb, fop);
                    m_out = r.res;  m_flags = r.flags;  m_err = 1'b0;  m_countdown = 2;
                    m_alu_a = fa;   m_alu_b = fb;       m_alu_ctrl = fop;
                end else begin
                    m_out = '0;  m_flags = '0;  m_err = 1'b1;  m_countdown = 1;
                end
            end
        end
    endtask

    initial begin
        // Reset values
        do_reset();
        @(negedge clk);
        check_reset_vals("reset");
        tick();

        // Single requester: 5 - 3
        bus.resp_ready = '1;
        set_req(0, 1'b1, 32'd5, 32'd3, 4'b0001);
        @(negedge clk);
        check("t1_grant", bus.req_ready, 3'b001);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        check("t1_alu_a", alu_a, 5);
        check("t1_alu_b", alu_b, 3);
        check("t1_alu_ctrl", alu_ctrl, 1);
        check("t1_busy", busy, 1);
        check("t1_no_early_resp", bus.resp_valid, 0);
        tick();
        @(negedge clk);
        check("t1_resp_valid", bus.resp_valid, 3'b001);
        check("t1_resp_out", bus.resp_out, 2);
        check("t1_resp_flags", bus.resp_flags, 4'b0100);
        check("t1_resp_err", bus.resp_err, 0);
        tick();
        @(negedge clk);
        check("t1_idle", busy, 0);
        tick();

        // Simultaneous requests held from reset: grants alternate 0,1,0,1
        do_reset();
        bus.resp_ready = '1;
        set_req(0, 1'b1, 32'd1, 32'd1, 4'd0);
        set_req(1, 1'b1, 32'hF0, 32'h0F, 4'd4);
        for (int g = 0; g < 4; g++) begin
            wait_for(1'b1, "t2_grant");
            check("t2_grant", bus.req_ready, (g % 2 == 0) ? 3'b001 : 3'b010);
            tick();
            wait_for(1'b0, "t2_resp");
            check("t2_resp_valid", bus.resp_valid, (g % 2 == 0) ? 3'b001 : 3'b010);
            check("t2_resp_out", bus.resp_out, (g % 2 == 0) ? 32'd2 : 32'hFF);
            tick();
        end
        bus.req_valid = '0;

        // Backpressure on req0 while req1 waits; non-owner resp_ready is ignored
        do_reset();
        bus.resp_ready = 3'b110;
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd5);
        set_req(1, 1'b1, 32'd7, 32'd8, 4'd3);
        wait_for(1'b1, "t3_grant");
        check("t3_grant", bus.req_ready, 3'b001);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_for(1'b0, "t3_resp");
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_valid", bus.resp_valid, 3'b001);
            check("t3_hold_out", bus.resp_out, 1);
            check("t3_hold_no_grant", bus.req_ready, 0);
            if (k < 4) begin
                tick();
                @(negedge clk);
            end
        end
        tick();
        bus.resp_ready = 3'b001;
        @(negedge clk);
        check("t3_last_resp", bus.resp_valid, 3'b001);
        tick();
        @(negedge clk);
        check("t3_req1_grant", bus.req_ready, 3'b010);
        tick();
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.resp_ready = '1;
        wait_for(1'b0, "t3_resp1");
        check("t3_resp1_valid", bus.resp_valid, 3'b010);
        check("t3_resp1_out", bus.resp_out, 15);
        tick();

        // Illegal opcode from req1: answered next cycle, ALU inputs untouched
        set_req(1, 1'b1, 32'h1234, 32'h5678, 4'b1111);
        @(negedge clk);
        check("t4_grant", bus.req_ready, 3'b010);
        tick();
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        check("t4_resp_valid", bus.resp_valid, 3'b010);
        check("t4_resp_err", bus.resp_err, 1);
        check("t4_resp_out", bus.resp_out, 0);
        check("t4_resp_flags", bus.resp_flags, 0);
        check("t4_alu_ctrl_held", alu_ctrl, 3);
        check("t4_alu_a_held", alu_a, 7);
        tick();
        @(negedge clk);
        check("t4_idle", busy, 0);
        tick();

        // Reset while a response is pending
        bus.resp_ready = '0;
        set_req(0, 1'b1, 32'd9, 32'd4, 4'd1);
        wait_for(1'b1, "t5_grant");
        check("t5_grant", bus.req_ready, 3'b001);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_for(1'b0, "t5_resp");
        check("t5_resp_valid", bus.resp_valid, 3'b001);
        check("t5_resp_out", bus.resp_out, 5);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("t5_reset");
        tick();
        @(negedge clk);
        check("t5_no_resp", bus.resp_valid, 0);
        tick();
        bus.resp_ready = '1;
        set_req(1, 1'b1, 32'd3, 32'd3, 4'd4);
        @(negedge clk);
        check("t5_req1_grant", bus.req_ready, 3'b010);
        tick();
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_for(1'b0, "t5_resp1");
        check("t5_resp1_valid", bus.resp_valid, 3'b010);
        check("t5_resp1_out", bus.resp_out, 0);
        check("t5_resp1_flags", bus.resp_flags, 4'b0001);
        tick();

        // Randomized traffic against the reference model
        do_reset();
        m_busy = 1'b0;  m_owner = 0;  m_countdown = 0;  m_rr = 0;
        m_out = '0;  m_flags = '0;  m_err = 1'b0;
        m_alu_a = '0;  m_alu_b = '0;  m_alu_ctrl = '0;
        for (int i = 0; i < NREQ; i++) granted[i] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_random();
            @(negedge clk);
            model_step();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
